// File: rtl/mem_map_package.sv
// Shared address map, bus source tags and FSM states for mem_io_bridge.
package mem_map_package;

  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned STATUS_W = 2;
  localparam int unsigned CNT_W    = 8;

  localparam logic [ADDR_W-1:0] RAM_TOP  = 16'h0FFF;
  localparam logic [ADDR_W-1:0] IO_OUT_A = 16'hF000;
  localparam logic [ADDR_W-1:0] IO_IN_A  = 16'hF001;
  localparam logic [ADDR_W-1:0] STATUS_A = 16'hF002;
  localparam logic [ADDR_W-1:0] LD_CNT_A = 16'hF003;
  localparam logic [ADDR_W-1:0] ST_CNT_A = 16'hF004;

  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

  typedef enum logic [2:0] {
    SRC_RAM,
    SRC_IO_OUT,
    SRC_IO_IN,
    SRC_STATUS,
    SRC_LD_CNT,
    SRC_ST_CNT,
    SRC_UNMAPPED
  } src_t;

  typedef enum logic {
    IDLE,
    RD_RESP
  } state_t;

  // Counter addresses only decode when the counters are built.
  function automatic src_t decode_addr(input logic [ADDR_W-1:0] addr, input logic cnt_en);
    src_t s;
    s = SRC_UNMAPPED;
    if (addr <= RAM_TOP)                  s = SRC_RAM;
    else if (addr == IO_OUT_A)            s = SRC_IO_OUT;
    else if (addr == IO_IN_A)             s = SRC_IO_IN;
    else if (addr == STATUS_A)            s = SRC_STATUS;
    else if (cnt_en && addr == LD_CNT_A)  s = SRC_LD_CNT;
    else if (cnt_en && addr == ST_CNT_A)  s = SRC_ST_CNT;
    return s;
  endfunction

endpackage

// File: rtl/mem_io_bridge_sync2.sv
// sync2: two-flop synchronizer for the asynchronous switch inputs.
module sync2 #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: CPU bus bridge to a sync-read RAM window, IO registers and sticky STATUS.
// Optional build macro ACCESS_COUNT_EN adds saturating RAM load/store counters at 0xF003/0xF004.
module mem_io_bridge
  import mem_map_package::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RAM_AW = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       cpu_Address,
  input  logic [DATA_W-1:0] cpu_Dout,
  output logic [DATA_W-1:0] cpu_Din,
  input  logic              cpu_Rden,
  input  logic              cpu_Wren,
  output logic [RAM_AW-1:0] mem_Address,
  output logic [DATA_W-1:0] mem_Din,
  input  logic [DATA_W-1:0] mem_Dout,
  output logic              mem_Rden,
  output logic              mem_Wren,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] io_out,
  output logic              bus_err
);

`ifdef ACCESS_COUNT_EN
  localparam logic CNT_EN = 1'b1;
`else
  localparam logic CNT_EN = 1'b0;
`endif

  state_t              state, state_next;
  src_t                src, rd_src;
  logic                rd_acc, wr_acc, ram_hit;
  logic [DATA_W-1:0]   io_sync, hold, resp_data;
  logic [STATUS_W-1:0] status, status_set, status_clr;

  // A simultaneous read/write is treated as a write only.
  assign src         = decode_addr(cpu_Address, CNT_EN);
  assign ram_hit     = (src == SRC_RAM);
  assign rd_acc      = cpu_Rden & ~cpu_Wren;
  assign wr_acc      = cpu_Wren;
  assign mem_Address = cpu_Address[RAM_AW-1:0];
  assign mem_Din     = cpu_Dout;
  assign mem_Rden    = rd_acc & ram_hit & ~reset;
  assign mem_Wren    = wr_acc & ram_hit & ~reset;
  assign bus_err     = |status;

  sync2 #(.W(DATA_W)) u_sync2 (
    .clk   (clk),
    .reset (reset),
    .d     (io_in),
    .q     (io_sync)
  );

`ifdef ACCESS_COUNT_EN
  logic [CNT_W-1:0] ld_cnt, st_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_cnt <= '0;
      st_cnt <= '0;
    end else begin
      if (rd_acc && ram_hit && ld_cnt != CNT_MAX) ld_cnt <= ld_cnt + CNT_W'(1);
      if (wr_acc && ram_hit && st_cnt != CNT_MAX) st_cnt <= st_cnt + CNT_W'(1);
    end
  end
`endif

  // Response data for the read issued last cycle, chosen by the registered tag.
  always_comb begin
    resp_data = '0;
    case (rd_src)
      SRC_RAM:    resp_data = mem_Dout;
      SRC_IO_OUT: resp_data = io_out;
      SRC_IO_IN:  resp_data = io_sync;
      SRC_STATUS: resp_data = DATA_W'(status);
`ifdef ACCESS_COUNT_EN
      SRC_LD_CNT: resp_data = DATA_W'(ld_cnt);
      SRC_ST_CNT: resp_data = DATA_W'(st_cnt);
`endif
      default:    resp_data = '0;
    endcase
  end

  always_comb begin
    state_next = IDLE;
    cpu_Din    = hold;
    case (state)
      IDLE: begin
        if (rd_acc) state_next = RD_RESP;
      end
      RD_RESP: begin
        cpu_Din = resp_data;
        if (rd_acc) state_next = RD_RESP;
      end
      default: state_next = IDLE;
    endcase
  end

  // Error sets are applied after clears so a same-cycle error survives a clear.
  always_comb begin
    status_set    = '0;
    status_clr    = '0;
    status_set[0] = (cpu_Rden | cpu_Wren) & (src == SRC_UNMAPPED);
    status_set[1] = cpu_Rden & cpu_Wren;
    if (wr_acc && src == SRC_STATUS) status_clr = cpu_Dout[STATUS_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_src <= SRC_UNMAPPED;
      hold   <= '0;
      io_out <= '0;
      status <= '0;
    end else begin
      if (rd_acc) rd_src <= src;
      if (state == RD_RESP) hold <= resp_data;
      if (wr_acc && src == SRC_IO_OUT) io_out <= cpu_Dout;
      status <= (status & ~status_clr) | status_set;
    end
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: address-level reference model plus directed literal checks.
module tb_mem_io_bridge;

`ifdef ACCESS_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_Address = '0;
  logic [15:0] cpu_Dout = '0;
  logic [15:0] cpu_Din;
  logic        cpu_Rden = 1'b0;
  logic        cpu_Wren = 1'b0;
  logic [11:0] mem_Address;
  logic [15:0] mem_Din;
  logic [15:0] mem_Dout = '0;
  logic        mem_Rden, mem_Wren;
  logic [15:0] io_in = '0;
  logic [15:0] io_out;
  logic        bus_err;

  int total = 0;
  int bad = 0;

  mem_io_bridge dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_Address (cpu_Address),
    .cpu_Dout    (cpu_Dout),
    .cpu_Din     (cpu_Din),
    .cpu_Rden    (cpu_Rden),
    .cpu_Wren    (cpu_Wren),
    .mem_Address (mem_Address),
    .mem_Din     (mem_Din),
    .mem_Dout    (mem_Dout),
    .mem_Rden    (mem_Rden),
    .mem_Wren    (mem_Wren),
    .io_in       (io_in),
    .io_out      (io_out),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  // External RAM device with one-cycle synchronous read.
  bit [15:0] env_ram [0:4095];
  always @(posedge clk) begin
    if (mem_Wren) env_ram[mem_Address] <= mem_Din;
    if (mem_Rden) mem_Dout <= env_ram[mem_Address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state updated once per rising edge.
  bit [15:0]   m_ram [0:4095];
  logic [15:0] m_io_out, m_last, m_resp, m_sync, m_q1;
  logic [1:0]  m_status;
  int          m_ld, m_st;
  bit          m_pend = 1'b0;
  bit          check_en = 1'b0;

  function automatic bit is_ram(input logic [15:0] a);
    return a < 16'h1000;
  endfunction

  function automatic bit is_mapped(input logic [15:0] a);
    return is_ram(a) || (a >= 16'hF000 && a <= 16'hF002) ||
           (CNT_EN && (a == 16'hF003 || a == 16'hF004));
  endfunction

  function automatic logic [15:0] value_of(input logic [15:0] a);
    if (is_ram(a)) return m_ram[a[11:0]];
    if (a == 16'hF000) return m_io_out;
    if (a == 16'hF001) return m_sync;
    if (a == 16'hF002) return {14'd0, m_status};
    if (CNT_EN && a == 16'hF003) return 16'(m_ld);
    if (CNT_EN && a == 16'hF004) return 16'(m_st);
    return 16'h0000;
  endfunction

  task automatic model_step();
    logic [1:0] set, clr;
    bit rd_ok;
    if (reset) begin
      m_io_out = '0; m_last = '0; m_sync = '0; m_q1 = '0;
      m_status = '0; m_ld = 0; m_st = 0; m_pend = 1'b0;
      check_en = 1'b1;
      return;
    end
    rd_ok = cpu_Rden && !cpu_Wren;
    if (m_pend) m_last = m_resp;
    m_pend = 1'b0;
    if (cpu_Wren) begin
      if (is_ram(cpu_Address)) begin
        m_ram[cpu_Address[11:0]] = cpu_Dout;
        if (m_st < 255) m_st++;
      end else if (cpu_Address == 16'hF000) begin
        m_io_out = cpu_Dout;
      end
    end
    if (rd_ok && is_ram(cpu_Address) && m_ld < 255) m_ld++;
    clr = (cpu_Wren && cpu_Address == 16'hF002) ? cpu_Dout[1:0] : 2'b00;
    set = {cpu_Rden && cpu_Wren, (cpu_Rden || cpu_Wren) && !is_mapped(cpu_Address)};
    m_status = (m_status & ~clr) | set;
    m_sync = m_q1;
    m_q1 = io_in;
    if (rd_ok) begin
      m_pend = 1'b1;
      m_resp = value_of(cpu_Address);
    end
  endtask

  // Compare process: checks every cycle after the first reset, then advances the model.
  initial begin
    logic exp_mr, exp_mw;
    forever begin
      @(negedge clk);
      #2;
      if (check_en) begin
        exp_mr = !reset && cpu_Rden && !cpu_Wren && is_ram(cpu_Address);
        exp_mw = !reset && cpu_Wren && is_ram(cpu_Address);
        chk("cpu_Din", 32'(cpu_Din), 32'(m_pend ? m_resp : m_last));
        chk("io_out", 32'(io_out), 32'(m_io_out));
        chk("bus_err", 32'(bus_err), 32'(|m_status));
        chk("mem_Rden", 32'(mem_Rden), 32'(exp_mr));
        chk("mem_Wren", 32'(mem_Wren), 32'(exp_mw));
        chk("mem_Address", 32'(mem_Address), 32'(cpu_Address[11:0]));
        chk("mem_Din", 32'(mem_Din), 32'(cpu_Dout));
      end
      @(posedge clk);
      model_step();
    end
  end

  task automatic step(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    reset = 1'b0;
    cpu_Rden = rd;
    cpu_Wren = wr;
    cpu_Address = a;
    cpu_Dout = d;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    cpu_Rden = 1'b0;
    cpu_Wren = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    int r;
    do_reset(2);
    idle(); #3;
    chk("rst_cpu_Din", 32'(cpu_Din), 32'h0);
    chk("rst_io_out", 32'(io_out), 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'h0);

    // RAM write then read with one-cycle latency and hold.
    step(1'b0, 1'b1, 16'h0010, 16'h1234); #3;
    chk("wr_mem_Wren", 32'(mem_Wren), 32'h1);
    chk("wr_mem_Address", 32'(mem_Address), 32'h010);
    step(1'b1, 1'b0, 16'h0010, 16'h0000); #3;
    chk("rd_mem_Rden", 32'(mem_Rden), 32'h1);
    idle(); #3;
    chk("ram_rd_data", 32'(cpu_Din), 32'h1234);
    idle(); #3;
    chk("ram_rd_hold", 32'(cpu_Din), 32'h1234);

    // IO_OUT write/read.
    step(1'b0, 1'b1, 16'hF000, 16'h00A5);
    idle(); #3;
    chk("io_out_wr", 32'(io_out), 32'h00A5);
    step(1'b1, 1'b0, 16'hF000, 16'h0000);
    idle(); #3;
    chk("io_out_rd", 32'(cpu_Din), 32'h00A5);

    // Unmapped read, STATUS read and clear.
    step(1'b1, 1'b0, 16'h2000, 16'h0000); #3;
    chk("unmap_mem_Rden", 32'(mem_Rden), 32'h0);
    idle(); #3;
    chk("unmap_rd_data", 32'(cpu_Din), 32'h0);
    chk("unmap_bus_err", 32'(bus_err), 32'h1);
    step(1'b1, 1'b0, 16'hF002, 16'h0000);
    idle(); #3;
    chk("status_unmap", 32'(cpu_Din), 32'h0001);
    step(1'b0, 1'b1, 16'hF002, 16'h0001);
    idle(); #3;
    chk("status_clr", 32'(bus_err), 32'h0);

    // Simultaneous read and write: write wins, no response.
    step(1'b1, 1'b1, 16'h0020, 16'h5555); #3;
    chk("both_mem_Wren", 32'(mem_Wren), 32'h1);
    chk("both_mem_Rden", 32'(mem_Rden), 32'h0);
    idle(); #3;
    chk("both_no_resp", 32'(cpu_Din), 32'h0001);
    chk("both_bus_err", 32'(bus_err), 32'h1);
    step(1'b1, 1'b0, 16'hF002, 16'h0000);
    idle(); #3;
    chk("status_both", 32'(cpu_Din), 32'h0002);
    step(1'b1, 1'b0, 16'h0020, 16'h0000);
    idle(); #3;
    chk("both_ram_data", 32'(cpu_Din), 32'h5555);
    step(1'b0, 1'b1, 16'hF002, 16'h0003);
    idle(); #3;
    chk("status_clr2", 32'(bus_err), 32'h0);

    // IO_IN through the synchronizer.
    idle();
    io_in = 16'hBEEF;
    idle();
    step(1'b1, 1'b0, 16'hF001, 16'h0000);
    idle(); #3;
    chk("io_in_rd", 32'(cpu_Din), 32'hBEEF);

    // Reset while a read response is pending.
    step(1'b0, 1'b1, 16'hF000, 16'h00C3);
    step(1'b1, 1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    cpu_Rden = 1'b1;
    cpu_Wren = 1'b0;
    cpu_Address = 16'h0010;
    #3;
    chk("rst_resp_visible", 32'(cpu_Din), 32'h1234);
    chk("rst_mem_Rden", 32'(mem_Rden), 32'h0);
    idle(); #3;
    chk("rst_rd_discard", 32'(cpu_Din), 32'h0);
    chk("rst_io_out2", 32'(io_out), 32'h0);

`ifdef ACCESS_COUNT_EN
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 16'(i % 64), 16'($urandom));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'(16'h0030 + i), 16'h0000);
    step(1'b1, 1'b0, 16'hF004, 16'h0000);
    idle(); #3;
    chk("st_cnt_sat", 32'(cpu_Din), 32'h00FF);
    step(1'b1, 1'b0, 16'hF003, 16'h0000);
    idle(); #3;
    chk("ld_cnt", 32'(cpu_Din), 32'h0003);
`else
    step(1'b1, 1'b0, 16'hF003, 16'h0000);
    idle(); #3;
    chk("ld_cnt_unmapped", 32'(cpu_Din), 32'h0);
    chk("ld_cnt_err", 32'(bus_err), 32'h1);
    step(1'b0, 1'b1, 16'hF002, 16'h0003);
`endif

    // Randomized traffic checked by the compare process.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 199) == 0);
      r = $urandom_range(0, 9);
      cpu_Rden = (r <= 3) || (r == 7);
      cpu_Wren = (r >= 4 && r <= 7);
      cpu_Dout = 16'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: cpu_Address = 16'($urandom_range(0, 31));
        5:             cpu_Address = 16'(16'h0FE0 + $urandom_range(0, 31));
        6, 7:          cpu_Address = 16'(16'hF000 + $urandom_range(0, 4));
        8:             cpu_Address = 16'($urandom_range(16'h1000, 16'hEFFF));
        default:       cpu_Address = 16'(16'hF005 + $urandom_range(0, 16'h0FFA));
      endcase
      if ($urandom_range(0, 3) == 0) io_in = 16'($urandom);
    end
    idle();
    idle();
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_io_bridge.md
MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

Interface
REQ-001 Parameter DATA_W, default 16: data bus width.
REQ-002 Parameter RAM_AW, default 12: RAM address width; RAM window is 0x0000..0x0FFF.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port reset  input  1: reset is synchronous and active-high.
REQ-005 Port cpu_Address  input  16: CPU byte-less word address.
REQ-006 Port cpu_Dout  input  DATA_W: write data from CPU.
REQ-007 Port cpu_Din  output  DATA_W: read data to CPU.
REQ-008 Port cpu_Rden  input  1: CPU read strobe, one cycle per access.
REQ-009 Port cpu_Wren  input  1: CPU write strobe, one cycle per access.
REQ-010 Port mem_Address  output  RAM_AW: RAM address, equal to cpu_Address[RAM_AW-1:0].
REQ-011 Port mem_Din / mem_Dout  output / input  DATA_W: RAM write data / RAM read data (RAM has 1-cycle synchronous read).
REQ-012 Port mem_Rden / mem_Wren  output  1: RAM strobes, asserted only for RAM-window accesses.
REQ-013 Port io_in  input  DATA_W: asynchronous switch inputs.
REQ-014 Port io_out  output  DATA_W: registered output port.
REQ-015 Port bus_err  output  1: sticky error flag.

Function
REQ-016 The decode shall be RAM for 0x0000..0x0FFF; 0xF000 IO_OUT (R/W); 0xF001 IO_IN (RO); 0xF002 STATUS (R, write-1-to-clear); all other addresses unmapped.
REQ-017 mem_Rden/mem_Wren shall be combinational copies of cpu_Rden/cpu_Wren gated by RAM-window hit; mem_Din shall equal cpu_Dout.
REQ-018 The FSM shall have states IDLE and RD_RESP; IDLE->RD_RESP on accepted read; RD_RESP->IDLE unconditionally, or RD_RESP->RD_RESP on a back-to-back read.
REQ-019 Read latency shall be exactly 1 cycle: cpu_Din valid in the cycle after cpu_Rden, selected by a registered source tag (RAM, IO_OUT, IO_IN, STATUS, UNMAPPED).
REQ-020 cpu_Din shall hold its last value until the next read completes (RAM data captured into a hold register in RD_RESP).
REQ-021 IO_OUT write shall update io_out one cycle after cpu_Wren; reads return current io_out.
REQ-022 IO_IN reads shall return io_in through a 2-flop synchronizer (total 3 cycles from io_in change to readable).
REQ-023 STATUS bit0 = unmapped access seen, bit1 = simultaneous Rden&Wren seen, others 0; bus_err = OR of STATUS bits.
REQ-024 Unmapped reads shall return 0 and set STATUS[0]; unmapped writes shall be dropped and set STATUS[0].
REQ-025 Simultaneous cpu_Rden and cpu_Wren: write performed, read ignored (no FSM transition, mem_Rden low), STATUS[1] set.
REQ-026 A STATUS write with data bit n = 1 clears bit n; a new error in the same cycle wins (bit stays set).

Reset
REQ-027 Reset shall force: FSM IDLE, cpu_Din 0, io_out 0, STATUS 0, bus_err 0, synchronizer flops 0, counters 0.
REQ-028 Reset during RD_RESP shall discard the pending read; cpu_Din shall be 0 in the cycle after reset.
REQ-029 mem_Rden/mem_Wren shall be forced low while reset is high.

Configuration
REQ-030 With ACCESS_COUNT_EN defined: 8-bit saturating counters LD_CNT (0xF003) and ST_CNT (0xF004), incremented per accepted RAM read/write, read-only, cleared by reset, holding at 0xFF.
REQ-031 Without ACCESS_COUNT_EN: no counters built; 0xF003/0xF004 are unmapped per REQ-024.

Structure
REQ-032 Address-map constants (RAM_TOP, IO_OUT_A, IO_IN_A, STATUS_A, LD_CNT_A, ST_CNT_A) and the source-tag enum shall live in a shared package mem_map_package.
REQ-033 The io_in synchronizer shall be the single sub-module sync2 (parameterized width).

Verification
REQ-034 Write 0x1234 to 0x0010, read 0x0010 -> mem_Wren pulse with mem_Address 0x010; cpu_Din = 0x1234 exactly 1 cycle after Rden.
REQ-035 Write 0x00A5 to 0xF000 -> io_out = 0x00A5 next cycle; read 0xF000 returns 0x00A5.
REQ-036 Read 0x2000 -> cpu_Din 0, bus_err 1, STATUS 0x0001; write 0x0001 to 0xF002 -> bus_err 0.
REQ-037 Rden and Wren together at 0x0020 data 0x5555 -> RAM written, no read response, STATUS[1] = 1.
REQ-038 Reset asserted in RD_RESP -> cpu_Din 0, FSM IDLE, io_out 0 after the reset cycle.
REQ-039 ACCESS_COUNT_EN: 300 RAM writes -> ST_CNT reads 0xFF; 3 RAM reads -> LD_CNT reads 0x03.
